// File: rtl/snake_body_engine.sv
// snake_body_engine
//   Body/state engine for the VGA snake game. Holds up to MAX_LEN signed
//   segment coordinates, advances the body one STEP per game tick, accepts
//   direction buttons (reverse and same-direction requests are dropped),
//   grows on food and checks wall/self collisions with a one-segment-per-cycle
//   scan after every step.
//
// Ports
//   CLK, RESET          clock, asynchronous active-high reset
//   tick                one-cycle game-step strobe
//   start               IDLE->PLAY, GG->IDLE
//   pause               toggles PLAY/PAUSE
//   btn_l/r/u/d         direction requests (level, priority L>R>U>D)
//   grow                food eaten pulse
//   rd_idx              segment read index
//   rd_x, rd_y          signed coordinates of segment rd_idx (0 when invalid)
//   rd_valid            rd_idx < length
//   length              current segment count
//   state               0 IDLE, 1 PLAY, 2 CHECK, 3 PAUSE, 4 GG
//   moved               one-cycle strobe after a collision-free step
//   gg                  high in GG
module snake_body_engine #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 4,
    parameter int COORD_W  = 12,
    parameter int STEP     = 36,
    parameter int START_X  = 144,
    parameter int START_Y  = 0,
    parameter int X_MIN    = -375,
    parameter int X_MAX    = 375,
    parameter int Y_MIN    = -275,
    parameter int Y_MAX    = 225
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      tick,
    input  logic                      start,
    input  logic                      pause,
    input  logic                      btn_l,
    input  logic                      btn_r,
    input  logic                      btn_u,
    input  logic                      btn_d,
    input  logic                      grow,
    input  logic [5:0]                rd_idx,
    output logic signed [COORD_W-1:0] rd_x,
    output logic signed [COORD_W-1:0] rd_y,
    output logic                      rd_valid,
    output logic [6:0]                length,
    output logic [2:0]                state,
    output logic                      moved,
    output logic                      gg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_CHECK = 3'd2,
        S_PAUSE = 3'd3,
        S_GG    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        DIR_R = 2'd0,
        DIR_L = 2'd1,
        DIR_U = 2'd2,
        DIR_D = 2'd3
    } dir_t;

    localparam logic [6:0] INIT_LEN_L = 7'(INIT_LEN);
    localparam logic [6:0] MAX_LEN_L  = 7'(MAX_LEN);
    localparam logic signed [COORD_W-1:0] STEP_C  = COORD_W'(STEP);
    localparam logic signed [COORD_W-1:0] X_MIN_C = COORD_W'(X_MIN);
    localparam logic signed [COORD_W-1:0] X_MAX_C = COORD_W'(X_MAX);
    localparam logic signed [COORD_W-1:0] Y_MIN_C = COORD_W'(Y_MIN);
    localparam logic signed [COORD_W-1:0] Y_MAX_C = COORD_W'(Y_MAX);

    state_t                      st;
    dir_t                        dir;
    dir_t                        next_dir;
    logic                        grow_pend;
    logic                        wall_phase;
    logic [5:0]                  scan_idx;
    logic signed [COORD_W-1:0]   seg_x [MAX_LEN];
    logic signed [COORD_W-1:0]   seg_y [MAX_LEN];

    logic                        btn_req;
    dir_t                        req_dir;
    logic                        btn_take;
    logic signed [COORD_W-1:0]   step_x;
    logic signed [COORD_W-1:0]   step_y;
    logic                        wall_hit;
    logic                        scan_hit;
    logic                        scan_last;
    logic                        grow_ok;
    logic                        grow_now;

    function automatic logic signed [COORD_W-1:0] init_x(input int i);
        if (i < INIT_LEN)
            return COORD_W'(START_X - i * STEP);
        return '0;
    endfunction

    function automatic logic signed [COORD_W-1:0] init_y(input int i);
        if (i < INIT_LEN)
            return COORD_W'(START_Y);
        return '0;
    endfunction

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_R:   return DIR_L;
            DIR_L:   return DIR_R;
            DIR_U:   return DIR_D;
            default: return DIR_U;
        endcase
    endfunction

    // Highest-priority button wins; it is only taken if it turns the snake.
    always_comb begin
        btn_req = 1'b1;
        req_dir = DIR_R;
        if (btn_l)      req_dir = DIR_L;
        else if (btn_r) req_dir = DIR_R;
        else if (btn_u) req_dir = DIR_U;
        else if (btn_d) req_dir = DIR_D;
        else            btn_req = 1'b0;
        btn_take = btn_req && (req_dir != dir) && (req_dir != opposite(dir));
    end

    always_comb begin
        step_x = '0;
        step_y = '0;
        case (next_dir)
            DIR_R:   step_x = STEP_C;
            DIR_L:   step_x = -STEP_C;
            DIR_U:   step_y = STEP_C;
            default: step_y = -STEP_C;
        endcase
    end

    // Head has already moved when CHECK runs, so seg[0] is the new head.
    assign wall_hit = (seg_x[0] <= X_MIN_C) || (seg_x[0] >= X_MAX_C) ||
                      (seg_y[0] <= Y_MIN_C) || (seg_y[0] >= Y_MAX_C);

    always_comb begin
        scan_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (scan_idx == 6'(i))
                scan_hit = (seg_x[i] == seg_x[0]) && (seg_y[i] == seg_y[0]);
        end
    end

    assign scan_last = ({1'b0, scan_idx} == (length - 7'd1));
    assign grow_ok   = grow && (length < MAX_LEN_L);
    // A grow arriving together with the tick is applied on that same tick.
    assign grow_now  = (grow_pend || grow) && (length < MAX_LEN_L);

    assign rd_valid = ({1'b0, rd_idx} < length);

    always_comb begin
        rd_x = '0;
        rd_y = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (rd_valid && (rd_idx == 6'(i))) begin
                rd_x = seg_x[i];
                rd_y = seg_y[i];
            end
        end
    end

    assign state = st;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            st         <= S_IDLE;
            length     <= INIT_LEN_L;
            dir        <= DIR_R;
            next_dir   <= DIR_R;
            grow_pend  <= 1'b0;
            moved      <= 1'b0;
            gg         <= 1'b0;
            wall_phase <= 1'b0;
            scan_idx   <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= init_x(i);
                seg_y[i] <= init_y(i);
            end
        end else begin
            moved <= 1'b0;
            case (st)
                S_IDLE: begin
                    // Body is pinned to its start position until play begins.
                    for (int i = 0; i < MAX_LEN; i++) begin
                        seg_x[i] <= init_x(i);
                        seg_y[i] <= init_y(i);
                    end
                    length    <= INIT_LEN_L;
                    grow_pend <= 1'b0;
                    dir       <= DIR_R;
                    next_dir  <= DIR_R;
                    gg        <= 1'b0;
                    if (start)
                        st <= S_PLAY;
                end

                S_PLAY: begin
                    // Button is judged against the pre-tick dir; a tick in the
                    // same cycle still uses the old next_dir.
                    if (btn_take)
                        next_dir <= req_dir;
                    if (pause) begin
                        st <= S_PAUSE;
                        if (grow_ok)
                            grow_pend <= 1'b1;
                    end else if (tick) begin
                        seg_x[0] <= seg_x[0] + step_x;
                        seg_y[0] <= seg_y[0] + step_y;
                        for (int i = 1; i < MAX_LEN; i++) begin
                            seg_x[i] <= seg_x[i-1];
                            seg_y[i] <= seg_y[i-1];
                        end
                        dir <= next_dir;
                        if (grow_now)
                            length <= length + 7'd1;
                        grow_pend  <= 1'b0;
                        wall_phase <= 1'b1;
                        scan_idx   <= 6'd1;
                        st         <= S_CHECK;
                    end else if (grow_ok) begin
                        grow_pend <= 1'b1;
                    end
                end

                S_CHECK: begin
                    if (btn_take)
                        next_dir <= req_dir;
                    if (grow_ok)
                        grow_pend <= 1'b1;
                    if (wall_phase) begin
                        wall_phase <= 1'b0;
                        if (wall_hit) begin
                            st <= S_GG;
                            gg <= 1'b1;
                        end else if (length == 7'd1) begin
                            moved <= 1'b1;
                            st    <= S_PLAY;
                        end
                    end else if (scan_hit) begin
                        st <= S_GG;
                        gg <= 1'b1;
                    end else if (scan_last) begin
                        moved <= 1'b1;
                        st    <= S_PLAY;
                    end else begin
                        scan_idx <= scan_idx + 6'd1;
                    end
                end

                S_PAUSE: begin
                    if (grow_ok)
                        grow_pend <= 1'b1;
                    if (pause)
                        st <= S_PLAY;
                end

                S_GG: begin
                    if (start) begin
                        st        <= S_IDLE;
                        gg        <= 1'b0;
                        length    <= INIT_LEN_L;
                        grow_pend <= 1'b0;
                        dir       <= DIR_R;
                        next_dir  <= DIR_R;
                        for (int i = 0; i < MAX_LEN; i++) begin
                            seg_x[i] <= init_x(i);
                            seg_y[i] <= init_y(i);
                        end
                    end
                end

                default: st <= S_IDLE;
            endcase
        end
    end

endmodule
